hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline control counterpart to the forwarding unit.
- The forwarding unit supplies operands when a hazard can be bypassed; this block detects the hazards it cannot bypass and resolves them by stalling, inserting bubbles, flushing and redirecting the PC.
- Sits beside the 5-stage MIPS datapath and drives every pipeline-latch enable/flush, PC enable and PC redirect.
- Holds a sticky halt and a pending-redirect register across icache misses.

Parameters:
- NONE_SHARED, n/a: widths come from cpu_types_pkg (word_t 32b, regbits_t 5b); the block has no local parameters.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- ihit  input  1  icache returned the instruction for the current PC
- dhit  input  1  dcache completed the MEM-stage access
- mem_dREN  input  1  MEM-stage load request
- mem_dWEN  input  1  MEM-stage store request
- id_rs  input  5  ID-stage source register rs
- id_rt  input  5  ID-stage source register rt
- id_usesRt  input  1  ID instruction reads rt as a source
- ex_memRead  input  1  EX-stage instruction is a load
- ex_dest  input  5  EX-stage destination register
- mem_brTaken  input  1  MEM stage resolved a taken branch or jump
- mem_target  input  32  redirect target from MEM
- mem_halt  input  1  HALT has reached MEM
- pc_en  output  1  PC register load enable
- pc_redirect  output  1  PC mux selects redirect_pc
- redirect_pc  output  32  latched redirect target
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  output  1 each  synchronous bubble insert, applied on the same edge as the enable
- halt  output  1  sticky processor halt

Behaviour:
- States: RUN, FLUSH_PEND, HALTED. State is held in a 2-bit enum.
- Reset (nRST=0, asynchronous):
  - state=RUN, redirect_pc=0.
  - All flush outputs 0, pc_redirect=0, halt=0.
  - pc_en and all *_en outputs 0 while reset is asserted.
- Derived terms:
  - freeze = (mem_dREN|mem_dWEN) & !dhit
  - loaduse = ex_memRead & ex_dest!=0 & (ex_dest==id_rs | (id_usesRt & ex_dest==id_rt))
- Priority (highest first):
  1. HALTED
  2. freeze
  3. mem_halt
  4. mem_brTaken
  5. loaduse
  6. !ihit
- HALTED:
  - All enables 0, halt=1.
  - Exit only through reset.
- freeze (any state other than HALTED):
  - All enables 0, all flushes 0. State and redirect_pc are held.
  - A simultaneous mem_brTaken or mem_halt is acted on only in the cycle dhit rises, because MEM holds those inputs steady until then.
- RUN, mem_halt:
  - memwb_en=1 so the preceding instruction retires; all other enables 0.
  - Next state HALTED; halt rises next cycle.
- RUN, mem_brTaken, ihit=1:
  - pc_en=1, pc_redirect=1, PC loads mem_target combinationally.
  - ifid_flush, idex_flush and exmem_flush = 1. All enables = 1.
  - Stays in RUN.
- RUN, mem_brTaken, ihit=0:
  - The in-flight fetch is wrong-path.
  - redirect_pc <= mem_target.
  - idex_flush=1, exmem_flush=1, idex/exmem/memwb enables=1.
  - pc_en=0, ifid_en=0.
  - Next state FLUSH_PEND.
- FLUSH_PEND:
  - pc_redirect=1.
  - On ihit: pc_en=1, ifid_en=1, ifid_flush=1 (the stale instruction is discarded), next state RUN.
  - Otherwise pc_en=0, ifid_en=0.
  - Back end advances: idex_flush=1 bubble each cycle, exmem/memwb enables=1.
- RUN, loaduse:
  - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1 (one bubble); exmem/memwb enables=1.
  - The bubble clears the condition on the next cycle because the load moves to MEM; exactly one bubble per load-use.
- RUN, !ihit:
  - pc_en=0, ifid_en=0, idex_flush=1; back end advances.
- RUN, no event: all enables 1, all flushes 0.
- Boundary cases:
  - ex_dest=0 never stalls.
  - loaduse concurrent with mem_brTaken: branch wins; the load-use instruction is flushed.
  - Reset in FLUSH_PEND discards redirect_pc.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs stall_cnt, bubble_cnt and flush_cnt, 32 bits each, reset to 0.
  - stall_cnt increments on every freeze cycle.
  - bubble_cnt increments on every loaduse bubble.
  - flush_cnt increments once per taken redirect, counted at mem_brTaken, not at the FLUSH_PEND exit.
  - All counters saturate at 32'hFFFFFFFF and freeze while halt=1.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- hazard_state_t enum (RUN, FLUSH_PEND, HALTED) goes in cpu_types_pkg beside the existing fwdMux-style types.
- Interface hazard_unit_if with modport hu carries the ports listed above.
- One natural sub-module, hazard_detect: purely combinational loaduse/freeze decode, reusable by the verification scoreboard.

Test Plan:
- lw $2 in EX with ex_memRead=1, ID uses rs=$2 -> 1 cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal flow; with id_rs=$0 and ex_dest=0 -> no stall.
- mem_dREN=1, dhit=0 for 3 cycles -> all enables 0 for 3 cycles; dhit=1 -> all enables 1.
- mem_brTaken=1, mem_target=32'h0000_0040, ihit=1 -> pc_redirect=1, pc_en=1, three flushes asserted in the same cycle.
- mem_brTaken with ihit=0, then ihit low 2 more cycles, then high -> redirect_pc=32'h40 held, state FLUSH_PEND, ifid_flush=1 only in the ihit cycle, then RUN.
- mem_halt=1 while mem_brTaken=1 -> halt=1 next cycle, all enables 0 thereafter; nRST pulse mid-FLUSH_PEND -> RUN, redirect_pc=0.
- HAZARD_STATS_EN: 2 load-use stalls, 5 freeze cycles and 1 redirect -> bubble_cnt=2, stall_cnt=5, flush_cnt=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, forwarding mux selects
// and the hazard unit's control state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_MEM,
    FWD_WB
  } fwdMux_t;

  typedef enum logic [1:0] {
    RUN,
    FLUSH_PEND,
    HALTED
  } hazard_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline hazard control bundle between the datapath and hazard_unit.
// The statistics counters exist only when HAZARD_STATS_EN is defined.
interface hazard_unit_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     mem_dREN;
  logic     mem_dWEN;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     id_usesRt;
  logic     ex_memRead;
  regbits_t ex_dest;
  logic     mem_brTaken;
  word_t    mem_target;
  logic     mem_halt;

  logic     pc_en;
  logic     pc_redirect;
  word_t    redirect_pc;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     halt;
`ifdef HAZARD_STATS_EN
  word_t    stall_cnt;
  word_t    bubble_cnt;
  word_t    flush_cnt;
`endif

  modport hu (
    input  ihit, dhit, mem_dREN, mem_dWEN, id_rs, id_rt, id_usesRt,
           ex_memRead, ex_dest, mem_brTaken, mem_target, mem_halt,
    output pc_en, pc_redirect, redirect_pc, ifid_en, idex_en, exmem_en,
           memwb_en, ifid_flush, idex_flush, exmem_flush, halt
`ifdef HAZARD_STATS_EN
    , output stall_cnt, bubble_cnt, flush_cnt
`endif
  );

  modport dp (
    output ihit, dhit, mem_dREN, mem_dWEN, id_rs, id_rt, id_usesRt,
           ex_memRead, ex_dest, mem_brTaken, mem_target, mem_halt,
    input  pc_en, pc_redirect, redirect_pc, ifid_en, idex_en, exmem_en,
           memwb_en, ifid_flush, idex_flush, exmem_flush, halt
`ifdef HAZARD_STATS_EN
    , input stall_cnt, bubble_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_unit_detect.sv
// Combinational decode of the two non-bypassable hazards: dcache freeze and
// load-use. Kept separate so a scoreboard can reuse the same decode.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     i_mem_dREN,
  input  logic     i_mem_dWEN,
  input  logic     i_dhit,
  input  regbits_t i_id_rs,
  input  regbits_t i_id_rt,
  input  logic     i_id_usesRt,
  input  logic     i_ex_memRead,
  input  regbits_t i_ex_dest,
  output logic     o_freeze,
  output logic     o_loaduse
);

  assign o_freeze  = (i_mem_dREN | i_mem_dWEN) & ~i_dhit;

  // $0 is hardwired, so a load into it can never create a dependency.
  assign o_loaduse = i_ex_memRead & (i_ex_dest != '0) &
                     ((i_ex_dest == i_id_rs) |
                      (i_id_usesRt & (i_ex_dest == i_id_rt)));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/redirect controller for the 5-stage MIPS datapath.
// Define HAZARD_STATS_EN to add saturating stall/bubble/flush counters.
module hazard_unit
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  hazard_unit_if.hu hif
);

  hazard_state_t r_state, w_next_state;
  word_t         r_redirect_pc, w_next_redirect_pc;
  logic          w_freeze, w_loaduse;
  logic          w_pc_en, w_pc_redirect, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic          w_ifid_flush, w_idex_flush, w_exmem_flush;
  logic          w_cnt_stall, w_cnt_bubble, w_cnt_flush;

  hazard_detect u_detect (
    .i_mem_dREN   (hif.mem_dREN),
    .i_mem_dWEN   (hif.mem_dWEN),
    .i_dhit       (hif.dhit),
    .i_id_rs      (hif.id_rs),
    .i_id_rt      (hif.id_rt),
    .i_id_usesRt  (hif.id_usesRt),
    .i_ex_memRead (hif.ex_memRead),
    .i_ex_dest    (hif.ex_dest),
    .o_freeze     (w_freeze),
    .o_loaduse    (w_loaduse)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= RUN;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_next_state;
      r_redirect_pc <= w_next_redirect_pc;
    end
  end

  // Everything is gated by nRST so the pipeline is fully stopped during reset.
  always_comb begin
    w_next_state       = r_state;
    w_next_redirect_pc = r_redirect_pc;
    w_pc_en       = 1'b0;
    w_pc_redirect = 1'b0;
    w_ifid_en     = 1'b0;
    w_idex_en     = 1'b0;
    w_exmem_en    = 1'b0;
    w_memwb_en    = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_cnt_stall   = 1'b0;
    w_cnt_bubble  = 1'b0;
    w_cnt_flush   = 1'b0;
    if (nRST && r_state != HALTED) begin
      if (w_freeze) begin
        w_cnt_stall = 1'b1;
      end else if (r_state == FLUSH_PEND) begin
        w_pc_redirect = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_idex_flush  = 1'b1;
        if (hif.ihit) begin
          w_pc_en      = 1'b1;
          w_ifid_en    = 1'b1;
          w_ifid_flush = 1'b1;
          w_next_state = RUN;
        end
      end else if (hif.mem_halt) begin
        w_memwb_en   = 1'b1;
        w_next_state = HALTED;
      end else if (hif.mem_brTaken) begin
        w_cnt_flush   = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_flush = 1'b1;
        if (hif.ihit) begin
          w_pc_en       = 1'b1;
          w_pc_redirect = 1'b1;
          w_ifid_en     = 1'b1;
          w_ifid_flush  = 1'b1;
        end else begin
          w_next_redirect_pc = hif.mem_target;
          w_next_state       = FLUSH_PEND;
        end
      end else if (w_loaduse || !hif.ihit) begin
        w_cnt_bubble = w_loaduse;
        w_idex_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
        w_idex_flush = 1'b1;
      end else begin
        w_pc_en    = 1'b1;
        w_ifid_en  = 1'b1;
        w_idex_en  = 1'b1;
        w_exmem_en = 1'b1;
        w_memwb_en = 1'b1;
      end
    end
  end

  // A same-cycle redirect uses mem_target directly; the latch serves FLUSH_PEND.
  assign hif.redirect_pc = (r_state == FLUSH_PEND) ? r_redirect_pc :
                           (w_pc_redirect ? hif.mem_target : r_redirect_pc);
  assign hif.pc_en       = w_pc_en;
  assign hif.pc_redirect = w_pc_redirect;
  assign hif.ifid_en     = w_ifid_en;
  assign hif.idex_en     = w_idex_en;
  assign hif.exmem_en    = w_exmem_en;
  assign hif.memwb_en    = w_memwb_en;
  assign hif.ifid_flush  = w_ifid_flush;
  assign hif.idex_flush  = w_idex_flush;
  assign hif.exmem_flush = w_exmem_flush;
  assign hif.halt        = (r_state == HALTED);

`ifdef HAZARD_STATS_EN
  word_t r_stall_cnt, r_bubble_cnt, r_flush_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_cnt_stall && r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_cnt_bubble && r_bubble_cnt != 32'hFFFF_FFFF)
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_cnt_flush && r_flush_cnt != 32'hFFFF_FFFF)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign hif.stall_cnt  = r_stall_cnt;
  assign hif.bubble_cnt = r_bubble_cnt;
  assign hif.flush_cnt  = r_flush_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = w_cnt_stall ^ w_cnt_bubble ^ w_cnt_flush;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_hazard_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  hazard_unit_if hif ();
  hazard_unit dut (.CLK(CLK), .nRST(nRST), .hif(hif));

  int checks = 0;
  int errors = 0;

  // Reference model: halted flag, waiting-for-redirect flag, latched target.
  bit          mHalted;
  bit          mPend;
  logic [31:0] mTarget;
  logic [31:0] mStall, mBubble, mFlush;

  function automatic bit modelFreeze();
    return (hif.mem_dREN || hif.mem_dWEN) && !hif.dhit;
  endfunction

  function automatic bit modelLoadUse();
    if (!hif.ex_memRead || hif.ex_dest == 5'd0) return 1'b0;
    return (hif.ex_dest == hif.id_rs) || (hif.id_usesRt && hif.ex_dest == hif.id_rt);
  endfunction

  // {pc_en,pc_redirect,ifid_en,idex_en,exmem_en,memwb_en,ifid_fl,idex_fl,exmem_fl}
  function automatic logic [8:0] expCtl();
    if (!nRST || mHalted || modelFreeze()) return 9'b000_000_000;
    if (mPend) return hif.ihit ? 9'b111_111_110 : 9'b010_111_010;
    if (hif.mem_halt) return 9'b000_001_000;
    if (hif.mem_brTaken) return hif.ihit ? 9'b111_111_111 : 9'b000_111_011;
    if (modelLoadUse() || !hif.ihit) return 9'b000_111_010;
    return 9'b101_111_000;
  endfunction

  function automatic logic [31:0] expRedirect();
    if (nRST && !mHalted && !modelFreeze() && !mPend && !hif.mem_halt &&
        hif.mem_brTaken && hif.ihit)
      return hif.mem_target;
    return mTarget;
  endfunction

  task automatic resetModel();
    mHalted = 0; mPend = 0; mTarget = '0;
    mStall = '0; mBubble = '0; mFlush = '0;
  endtask

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic modelUpdate();
    if (!nRST) begin
      resetModel();
    end else if (!mHalted) begin
      if (modelFreeze()) begin
        mStall = satInc(mStall);
      end else if (mPend) begin
        if (hif.ihit) mPend = 0;
      end else if (hif.mem_halt) begin
        mHalted = 1;
      end else if (hif.mem_brTaken) begin
        mFlush = satInc(mFlush);
        if (!hif.ihit) begin
          mPend = 1;
          mTarget = hif.mem_target;
        end
      end else if (modelLoadUse()) begin
        mBubble = satInc(mBubble);
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [8:0] obs, exp;
    obs = {hif.pc_en, hif.pc_redirect, hif.ifid_en, hif.idex_en, hif.exmem_en,
           hif.memwb_en, hif.ifid_flush, hif.idex_flush, hif.exmem_flush};
    exp = expCtl();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (hif.redirect_pc === expRedirect()) else begin
      errors++;
      $error("[TB] FAIL %s redirect_pc observed=%h expected=%h", tag, hif.redirect_pc, expRedirect());
    end
    checks++;
    assert (hif.halt === mHalted) else begin
      errors++;
      $error("[TB] FAIL %s halt observed=%b expected=%b", tag, hif.halt, mHalted);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    assert ({hif.stall_cnt, hif.bubble_cnt, hif.flush_cnt} === {mStall, mBubble, mFlush}) else begin
      errors++;
      $error("[TB] FAIL %s counters observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
             hif.stall_cnt, hif.bubble_cnt, hif.flush_cnt, mStall, mBubble, mFlush);
    end
`endif
  endtask

  // Inputs are set by the caller just after a rising edge; check mid-cycle.
  task automatic applyStimulus(input string tag);
    @(negedge CLK);
    checkOutput(tag);
    @(posedge CLK);
    modelUpdate();
    #1;
  endtask

  task automatic idle();
    hif.ihit = 1; hif.dhit = 0; hif.mem_dREN = 0; hif.mem_dWEN = 0;
    hif.id_rs = 5'd1; hif.id_rt = 5'd3; hif.id_usesRt = 1;
    hif.ex_memRead = 0; hif.ex_dest = 5'd0;
    hif.mem_brTaken = 0; hif.mem_target = '0; hif.mem_halt = 0;
  endtask

  initial begin
    nRST = 0;
    idle();
    resetModel();
    #12;
    checkOutput("reset_hold");
    @(posedge CLK); #1;
    nRST = 1;
    applyStimulus("run_idle");

    hif.ex_memRead = 1; hif.ex_dest = 5'd2; hif.id_rs = 5'd2;
    applyStimulus("loaduse_rs");
    hif.ex_memRead = 0;
    applyStimulus("loaduse_release");

    hif.ex_memRead = 1; hif.ex_dest = 5'd0; hif.id_rs = 5'd0;
    applyStimulus("dest_zero_no_stall");
    hif.ex_dest = 5'd7; hif.id_rs = 5'd1; hif.id_rt = 5'd7; hif.id_usesRt = 1;
    applyStimulus("loaduse_rt");
    hif.id_usesRt = 0;
    applyStimulus("rt_unused_no_stall");
    idle();

    hif.mem_dREN = 1; hif.dhit = 0;
    for (int i = 0; i < 3; i++) applyStimulus("freeze");
    hif.dhit = 1;
    applyStimulus("freeze_release");
    idle();

    hif.mem_brTaken = 1; hif.mem_target = 32'h0000_0040;
    hif.ex_memRead = 1; hif.ex_dest = 5'd1;
    applyStimulus("branch_ihit_over_loaduse");
    idle();

    hif.mem_brTaken = 1; hif.mem_target = 32'h0000_0040; hif.ihit = 0;
    applyStimulus("branch_miss");
    idle(); hif.ihit = 0;
    applyStimulus("flush_pend_1");
    applyStimulus("flush_pend_2");
    hif.ihit = 1;
    applyStimulus("flush_pend_exit");
    applyStimulus("back_to_run");

    for (int i = 0; i < 400; i++) begin
      hif.ihit       = ($urandom_range(0, 3) != 0);
      hif.dhit       = $urandom_range(0, 1);
      hif.mem_dREN   = ($urandom_range(0, 3) == 0);
      hif.mem_dWEN   = ($urandom_range(0, 5) == 0);
      hif.id_rs      = 5'($urandom_range(0, 3));
      hif.id_rt      = 5'($urandom_range(0, 3));
      hif.id_usesRt  = $urandom_range(0, 1);
      hif.ex_dest    = 5'($urandom_range(0, 3));
      hif.ex_memRead = !mPend && ($urandom_range(0, 1) == 1);
      hif.mem_brTaken = !mPend && ($urandom_range(0, 5) == 0);
      hif.mem_target = $urandom;
      hif.mem_halt   = 0;
      applyStimulus("random");
    end
    idle();
    applyStimulus("drain_1");
    applyStimulus("drain_2");

    hif.mem_brTaken = 1; hif.mem_target = 32'h0000_0080; hif.ihit = 0;
    applyStimulus("enter_pend");
    idle(); hif.ihit = 0;
    #2;
    nRST = 0;
    resetModel();
    #1;
    checkOutput("async_reset_in_pend");
    @(posedge CLK); #1;
    nRST = 1;
    hif.ihit = 1;
    applyStimulus("after_reset_run");

`ifdef HAZARD_STATS_EN
    for (int i = 0; i < 2; i++) begin
      idle(); hif.ex_memRead = 1; hif.ex_dest = 5'd4; hif.id_rs = 5'd4;
      applyStimulus("stats_loaduse");
      idle();
      applyStimulus("stats_gap");
    end
    hif.mem_dWEN = 1; hif.dhit = 0;
    for (int i = 0; i < 5; i++) applyStimulus("stats_freeze");
    idle();
    hif.mem_brTaken = 1; hif.mem_target = 32'h0000_0100;
    applyStimulus("stats_redirect");
    idle();
    @(negedge CLK);
    checks++;
    assert ({hif.bubble_cnt, hif.stall_cnt, hif.flush_cnt} === {32'd2, 32'd5, 32'd1}) else begin
      errors++;
      $error("[TB] FAIL stats_totals observed=%0d/%0d/%0d expected=2/5/1",
             hif.bubble_cnt, hif.stall_cnt, hif.flush_cnt);
    end
    @(posedge CLK); #1;
`endif

    hif.mem_halt = 1; hif.mem_brTaken = 1; hif.mem_target = 32'h0000_0200;
    applyStimulus("halt_with_branch");
    idle();
    for (int i = 0; i < 3; i++) applyStimulus("halted");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
